ex_mem_reg: RTL and testbench

EX/MEM pipeline boundary register with a two-entry skid buffer. It captures the ALU result together with the memory and writeback control that travel with it, and presents them to the MEM stage through a valid/ready handshake. When the load/store unit back-pressures, ready to EX stays registered, so the EX→MEM path has no combinational ready chain. It also flags misaligned memory accesses, so MEM sees the flag with the payload.

---
 rtl/core_pkg.sv | 52 +++++
 rtl/ex_mem_reg_if.sv | 34 +++
 rtl/ex_mem_skid.sv | 76 +++++++
 rtl/ex_mem_reg.sv | 50 +++++
 tb/tb_ex_mem_reg.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Core-wide widths and the EX/MEM boundary types shared by the pipeline register,
// its skid buffer and the bus interface.
package core_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_MEM,
    WB_PC4
  } wb_sel_e;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StTwo
  } ex_mem_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [DATA_WIDTH-1:0]     store_data;
    logic [DATA_WIDTH-1:0]     pc_plus4;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic [1:0]                mem_size;
    logic                      mem_unsigned;
    wb_sel_e                   wb_sel;
    logic                      misaligned;
  } ex_mem_payload_t;

  localparam int unsigned PAYLOAD_WIDTH = $bits(ex_mem_payload_t);

  // Only loads and stores can be misaligned; byte accesses never are.
  function automatic logic is_misaligned(logic [1:0] addr_lo, logic [1:0] size,
                                         logic mem_access);
    logic mis;
    unique case (size)
      MEM_HALF: mis = addr_lo[0];
      MEM_WORD: mis = |addr_lo;
      default:  mis = 1'b0;
    endcase
    return mem_access & mis;
  endfunction

endpackage

// File: rtl/ex_mem_reg_if.sv
// EX -> MEM boundary bus: producer-side payload and handshake plus the MEM-facing head entry.
interface ex_mem_reg_if;
  import core_pkg::*;

  logic                      ex_valid_i;
  logic                      ex_ready_o;
  logic [DATA_WIDTH-1:0]     alu_result_i;
  logic [DATA_WIDTH-1:0]     store_data_i;
  logic [DATA_WIDTH-1:0]     pc_plus4_i;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_i;
  logic                      reg_write_i;
  logic                      mem_read_i;
  logic                      mem_write_i;
  logic [1:0]                mem_size_i;
  logic                      mem_unsigned_i;
  wb_sel_e                   wb_sel_i;
  logic                      mem_valid_o;
  logic                      mem_ready_i;
  ex_mem_payload_t           mem_payload_o;
  logic                      misaligned_o;

  modport master (
    output ex_valid_i, alu_result_i, store_data_i, pc_plus4_i, rd_addr_i, reg_write_i,
           mem_read_i, mem_write_i, mem_size_i, mem_unsigned_i, wb_sel_i, mem_ready_i,
    input  ex_ready_o, mem_valid_o, mem_payload_o, misaligned_o
  );

  modport slave (
    input  ex_valid_i, alu_result_i, store_data_i, pc_plus4_i, rd_addr_i, reg_write_i,
           mem_read_i, mem_write_i, mem_size_i, mem_unsigned_i, wb_sel_i, mem_ready_i,
    output ex_ready_o, mem_valid_o, mem_payload_o, misaligned_o
  );

endinterface

// File: rtl/ex_mem_skid.sv
// Two-entry skid buffer with a registered upstream ready; the main register is the head and
// drives the outputs, the skid register absorbs the one accept that arrives before ready drops.
module ex_mem_skid
  import core_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  ex_mem_state_e    state_q;
  logic             ready_q;
  logic [Width-1:0] main_q;
  logic [Width-1:0] skid_q;
  logic             accept;
  logic             drain;

  assign accept    = in_valid & ready_q;
  assign drain     = (state_q != StEmpty) & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;

  // Flush leaves payload registers stale; only the state and ready are restored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= StEmpty;
      ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_q  <= in_data;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (accept && drain) begin
            main_q <= in_data;
          end else if (accept) begin
            skid_q  <= in_data;
            state_q <= StTwo;
            ready_q <= 1'b0;
          end else if (drain) begin
            state_q <= StEmpty;
          end
        end
        StTwo: begin
          if (drain) begin
            main_q  <= skid_q;
            state_q <= StOne;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StEmpty;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: packs the EX-stage payload, tags misaligned memory accesses on
// entry, and hands it to MEM through a registered-ready skid buffer.
module ex_mem_reg
  import core_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  ex_mem_reg_if.slave  bus
);

  ex_mem_payload_t          in_payload;
  logic [PAYLOAD_WIDTH-1:0] out_bits;
  ex_mem_payload_t          out_payload;

  always_comb begin
    in_payload              = '0;
    in_payload.alu_result   = bus.alu_result_i;
    in_payload.store_data   = bus.store_data_i;
    in_payload.pc_plus4     = bus.pc_plus4_i;
    in_payload.rd_addr      = bus.rd_addr_i;
    in_payload.reg_write    = bus.reg_write_i;
    in_payload.mem_read     = bus.mem_read_i;
    in_payload.mem_write    = bus.mem_write_i;
    in_payload.mem_size     = bus.mem_size_i;
    in_payload.mem_unsigned = bus.mem_unsigned_i;
    in_payload.wb_sel       = bus.wb_sel_i;
    in_payload.misaligned   = is_misaligned(bus.alu_result_i[1:0], bus.mem_size_i,
                                            bus.mem_read_i | bus.mem_write_i);
  end

  ex_mem_skid #(
    .Width (PAYLOAD_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_i),
    .in_valid  (bus.ex_valid_i),
    .in_ready  (bus.ex_ready_o),
    .in_data   (in_payload),
    .out_valid (bus.mem_valid_o),
    .out_ready (bus.mem_ready_i),
    .out_data  (out_bits)
  );

  assign out_payload       = ex_mem_payload_t'(out_bits);
  assign bus.mem_payload_o = out_payload;
  assign bus.misaligned_o  = out_payload.misaligned;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed scenarios plus random traffic, checked by a queue-based
// scoreboard that models the block as an ordered FIFO of at most two entries.
module tb_ex_mem_reg;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ex_mem_payload_t exp_q[$];

  ex_mem_reg_if bus ();

  ex_mem_reg dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference rule: an access of 2**size bytes must sit on a 2**size byte boundary.
  function automatic ex_mem_payload_t expect_of(ex_mem_payload_t p);
    ex_mem_payload_t e;
    int unsigned bytes;
    e = p;
    bytes = 1 << p.mem_size;
    e.misaligned = (p.mem_read || p.mem_write) && ((p.alu_result % bytes) != 0);
    return e;
  endfunction

  function automatic ex_mem_payload_t cur_inputs();
    ex_mem_payload_t p;
    p.alu_result   = bus.alu_result_i;
    p.store_data   = bus.store_data_i;
    p.pc_plus4     = bus.pc_plus4_i;
    p.rd_addr      = bus.rd_addr_i;
    p.reg_write    = bus.reg_write_i;
    p.mem_read     = bus.mem_read_i;
    p.mem_write    = bus.mem_write_i;
    p.mem_size     = bus.mem_size_i;
    p.mem_unsigned = bus.mem_unsigned_i;
    p.wb_sel       = bus.wb_sel_i;
    p.misaligned   = 1'b0;
    return p;
  endfunction

  // Monitor/model: outputs are compared mid-cycle, then the queue advances by the upcoming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      checks++;
      if (bus.mem_valid_o !== (exp_q.size() > 0)) begin
        errors++;
        $display("FAIL mem_valid got %b want %b", bus.mem_valid_o, exp_q.size() > 0);
      end
      checks++;
      if (bus.ex_ready_o !== (exp_q.size() < 2)) begin
        errors++;
        $display("FAIL ex_ready got %b want %b", bus.ex_ready_o, exp_q.size() < 2);
      end
      if (exp_q.size() > 0) begin
        checks++;
        if (bus.mem_payload_o !== exp_q[0]) begin
          errors++;
          $display("FAIL payload got %h want %h", bus.mem_payload_o, exp_q[0]);
        end
        checks++;
        if (bus.misaligned_o !== exp_q[0].misaligned) begin
          errors++;
          $display("FAIL misaligned got %b want %b addr %h", bus.misaligned_o,
                   exp_q[0].misaligned, exp_q[0].alu_result);
        end
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        bit acc;
        acc = bus.ex_valid_i && (exp_q.size() < 2);
        if (exp_q.size() > 0 && bus.mem_ready_i) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(expect_of(cur_inputs()));
      end
    end
  end

  task automatic drive(input ex_mem_payload_t p, input bit v, input bit mr, input bit fl);
    @(posedge clk);
    #1;
    bus.ex_valid_i     = v;
    bus.alu_result_i   = p.alu_result;
    bus.store_data_i   = p.store_data;
    bus.pc_plus4_i     = p.pc_plus4;
    bus.rd_addr_i      = p.rd_addr;
    bus.reg_write_i    = p.reg_write;
    bus.mem_read_i     = p.mem_read;
    bus.mem_write_i    = p.mem_write;
    bus.mem_size_i     = p.mem_size;
    bus.mem_unsigned_i = p.mem_unsigned;
    bus.wb_sel_i       = p.wb_sel;
    bus.mem_ready_i    = mr;
    flush              = fl;
  endtask

  function automatic ex_mem_payload_t mk(logic [31:0] addr, logic rd, logic wr,
                                         logic [1:0] size);
    ex_mem_payload_t p;
    p              = '0;
    p.alu_result   = addr;
    p.store_data   = addr ^ 32'hA5A5_0000;
    p.pc_plus4     = addr + 32'h4000;
    p.rd_addr      = addr[6:2];
    p.reg_write    = rd | ~wr;
    p.mem_read     = rd;
    p.mem_write    = wr;
    p.mem_size     = size;
    p.mem_unsigned = addr[3];
    p.wb_sel       = rd ? WB_MEM : WB_ALU;
    return p;
  endfunction

  function automatic ex_mem_payload_t rnd();
    ex_mem_payload_t p;
    p              = '0;
    p.alu_result   = $urandom;
    p.store_data   = $urandom;
    p.pc_plus4     = $urandom;
    p.rd_addr      = 5'($urandom_range(31, 0));
    p.reg_write    = 1'($urandom_range(1, 0));
    p.mem_read     = 1'($urandom_range(1, 0));
    p.mem_write    = p.mem_read ? 1'b0 : 1'($urandom_range(1, 0));
    p.mem_size     = 2'($urandom_range(2, 0));
    p.mem_unsigned = 1'($urandom_range(1, 0));
    p.wb_sel       = wb_sel_e'($urandom_range(2, 0));
    return p;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  initial begin
    ex_mem_payload_t idle;
    idle = '0;
    bus.ex_valid_i = 1'b0;
    bus.mem_ready_i = 1'b0;
    drive(idle, 1'b0, 1'b0, 1'b0);
    #2;
    chk("reset_valid", 128'(bus.mem_valid_o), 128'd0);
    chk("reset_ready", 128'(bus.ex_ready_o), 128'd1);
    chk("reset_payload", 128'(bus.mem_payload_o), 128'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Streaming stores, then overlapping accept/drain in ONE.
    for (int i = 0; i < 4; i++) drive(mk(32'h100 + 32'(4 * i), 1'b0, 1'b1, MEM_WORD), 1'b1, 1'b1, 1'b0);
    drive(idle, 1'b0, 1'b1, 1'b0);
    drive(idle, 1'b0, 1'b1, 1'b0);

    // Back-pressure with three offers, then release.
    for (int i = 0; i < 3; i++) drive(mk(32'h200 + 32'(4 * i), 1'b1, 1'b0, MEM_WORD), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(idle, 1'b0, 1'b1, 1'b0);

    // Flush while full, with an entry offered in the same cycle.
    for (int i = 0; i < 2; i++) drive(mk(32'h300 + 32'(4 * i), 1'b0, 1'b1, MEM_WORD), 1'b1, 1'b0, 1'b0);
    drive(mk(32'h3F0, 1'b0, 1'b1, MEM_WORD), 1'b1, 1'b0, 1'b1);
    drive(idle, 1'b0, 1'b1, 1'b0);
    drive(idle, 1'b0, 1'b1, 1'b0);

    // Misalignment corners: lw@0x102, lh@0x102, sh@0x103, alu result 0x3.
    drive(mk(32'h102, 1'b1, 1'b0, MEM_WORD), 1'b1, 1'b1, 1'b0);
    drive(mk(32'h102, 1'b1, 1'b0, MEM_HALF), 1'b1, 1'b1, 1'b0);
    drive(mk(32'h103, 1'b0, 1'b1, MEM_HALF), 1'b1, 1'b1, 1'b0);
    drive(mk(32'h3, 1'b0, 1'b0, MEM_WORD), 1'b1, 1'b1, 1'b0);
    drive(idle, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++)
      drive(rnd(), $urandom_range(9, 0) < 7, $urandom_range(9, 0) < 6, $urandom_range(19, 0) == 0);

    // Asynchronous reset mid-stream with two entries held.
    for (int i = 0; i < 3; i++) drive(mk(32'h400 + 32'(4 * i), 1'b1, 1'b0, MEM_WORD), 1'b1, 1'b0, 1'b0);
    drive(idle, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_valid", 128'(bus.mem_valid_o), 128'd0);
    chk("midreset_ready", 128'(bus.ex_ready_o), 128'd1);
    chk("midreset_payload", 128'(bus.mem_payload_o), 128'd0);
    chk("midreset_misaligned", 128'(bus.misaligned_o), 128'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(idle, 1'b0, 1'b1, 1'b0);
    drive(idle, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
